// File: rtl/hazard_scheduler.sv
// hazard_scheduler: stall/flush/forwarding control for the five-stage RV32I
// pipeline. A two-state FSM sequences multi-cycle load-use bubbles, a taken
// branch in execute overrides any stall, and saturating counters record
// stall, flush and load-hazard statistics.
module hazard_scheduler #(
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       RS1_D,
    input  logic [4:0]       RS2_D,
    input  logic [4:0]       RS1_E,
    input  logic [4:0]       RS2_E,
    input  logic [4:0]       RD_E,
    input  logic             RegWriteE,
    input  logic [1:0]       ResultSrcE,
    input  logic             PCSrcE,
    input  logic [4:0]       RD_M,
    input  logic             RegWriteM,
    input  logic [4:0]       RD_W,
    input  logic             RegWriteW,
    input  logic             cnt_clr,
    output logic             StallF,
    output logic             StallD,
    output logic             FlushD,
    output logic             flushD_load_hazard,
    output logic             flushD_branch_hazard,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] load_hz_cnt
);

    typedef enum logic [0:0] {
        ST_RUN      = 1'b0,
        ST_LD_STALL = 1'b1
    } state_t;

    // Remaining-bubble count loaded on detection; LOAD_LAT is at most 7.
    localparam logic [2:0]       REM_INIT    = 3'(LOAD_LAT - 1);
    localparam bit               MULTI_CYCLE = (LOAD_LAT > 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    state_t           state_q, state_d;
    logic [2:0]       rem_q, rem_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [CNT_W-1:0] load_hz_cnt_q, load_hz_cnt_d;

    logic lu_s;
    logic stall_s;
    logic branch_s;
    logic load_entry_s;

    // Saturating counter step; clear wins over increment.
    function automatic logic [CNT_W-1:0] cnt_step(input logic [CNT_W-1:0] cur,
                                                  input logic clr,
                                                  input logic inc);
        logic [CNT_W-1:0] res;
        if (clr) begin
            res = CNT_ZERO;
        end else if (inc && (cur != CNT_MAX)) begin
            res = cur + CNT_ONE;
        end else begin
            res = cur;
        end
        return res;
    endfunction

    // Bypass select for one execute operand; memory stage beats writeback, x0 never forwarded.
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                           input logic [4:0] rd_m,
                                           input logic       we_m,
                                           input logic [4:0] rd_w,
                                           input logic       we_w);
        logic [1:0] sel;
        if (we_m && (rd_m != 5'd0) && (rd_m == rs)) begin
            sel = 2'b10;
        end else if (we_w && (rd_w != 5'd0) && (rd_w == rs)) begin
            sel = 2'b01;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    assign lu_s = RegWriteE && (ResultSrcE == 2'b01) && (RD_E != 5'd0) &&
                  ((RD_E == RS1_D) || (RD_E == RS2_D));

    // FSM next state and Mealy stall/flush controls; a taken branch overrides everything.
    always_comb begin
        state_d      = state_q;
        rem_d        = rem_q;
        stall_s      = 1'b0;
        branch_s     = 1'b0;
        load_entry_s = 1'b0;
        if (PCSrcE) begin
            branch_s = 1'b1;
            state_d  = ST_RUN;
            rem_d    = 3'd0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (lu_s) begin
                        stall_s      = 1'b1;
                        load_entry_s = 1'b1;
                        rem_d        = REM_INIT;
                        state_d      = MULTI_CYCLE ? ST_LD_STALL : ST_RUN;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_LD_STALL: begin
                    // The cycle that drains the count is the last stall cycle.
                    stall_s = 1'b1;
                    if (rem_q <= 3'd1) begin
                        rem_d   = 3'd0;
                        state_d = ST_RUN;
                    end else begin
                        rem_d   = rem_q - 3'd1;
                        state_d = ST_LD_STALL;
                    end
                end
                default: begin
                    state_d = ST_RUN;
                    rem_d   = 3'd0;
                end
            endcase
        end
    end

    // Counter next values from this cycle's stall/flush/detection events.
    always_comb begin
        stall_cnt_d   = cnt_step(stall_cnt_q, cnt_clr, stall_s);
        flush_cnt_d   = cnt_step(flush_cnt_q, cnt_clr, branch_s);
        load_hz_cnt_d = cnt_step(load_hz_cnt_q, cnt_clr, load_entry_s);
    end

    // FSM state and remaining-bubble register; reset aborts any stall in progress.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_RUN;
            rem_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
        end
    end

    // Statistics counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q   <= CNT_ZERO;
            flush_cnt_q   <= CNT_ZERO;
            load_hz_cnt_q <= CNT_ZERO;
        end else begin
            stall_cnt_q   <= stall_cnt_d;
            flush_cnt_q   <= flush_cnt_d;
            load_hz_cnt_q <= load_hz_cnt_d;
        end
    end

    assign StallF               = stall_s;
    assign StallD               = stall_s;
    assign flushD_load_hazard   = stall_s;
    assign FlushD               = branch_s;
    assign flushD_branch_hazard = branch_s;
    assign ForwardAE            = fwd_sel(RS1_E, RD_M, RegWriteM, RD_W, RegWriteW);
    assign ForwardBE            = fwd_sel(RS2_E, RD_M, RegWriteM, RD_W, RegWriteW);
    assign stall_cnt            = stall_cnt_q;
    assign flush_cnt            = flush_cnt_q;
    assign load_hz_cnt          = load_hz_cnt_q;

endmodule

// File: tb/tb_hazard_scheduler.sv
// Testbench for hazard_scheduler: three instances (LOAD_LAT 1/3/4, the last
// with 4-bit counters) share one stimulus stream; directed scenarios plus a
// randomized run against a cycle-level behavioural model.
module tb_hazard_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic       regwrite_e, regwrite_m, regwrite_w, pcsrc_e, cnt_clr;
    logic [1:0] resultsrc_e;

    logic        stf [3];
    logic        std [3];
    logic        fd  [3];
    logic        fld [3];
    logic        flb [3];
    logic [1:0]  fae [3];
    logic [1:0]  fbe [3];
    logic [31:0] sc  [3];
    logic [31:0] fc  [3];
    logic [31:0] lc  [3];
    logic [3:0]  sc4, fc4, lc4;

    int checks   = 0;
    int failures = 0;

    assign sc[2] = {28'd0, sc4};
    assign fc[2] = {28'd0, fc4};
    assign lc[2] = {28'd0, lc4};

    always #5 clk = ~clk;

    hazard_scheduler #(.LOAD_LAT(1), .CNT_W(32)) u_l1 (
        .clk(clk), .rst(rst), .RS1_D(rs1_d), .RS2_D(rs2_d), .RS1_E(rs1_e), .RS2_E(rs2_e),
        .RD_E(rd_e), .RegWriteE(regwrite_e), .ResultSrcE(resultsrc_e), .PCSrcE(pcsrc_e),
        .RD_M(rd_m), .RegWriteM(regwrite_m), .RD_W(rd_w), .RegWriteW(regwrite_w),
        .cnt_clr(cnt_clr), .StallF(stf[0]), .StallD(std[0]), .FlushD(fd[0]),
        .flushD_load_hazard(fld[0]), .flushD_branch_hazard(flb[0]),
        .ForwardAE(fae[0]), .ForwardBE(fbe[0]),
        .stall_cnt(sc[0]), .flush_cnt(fc[0]), .load_hz_cnt(lc[0]));

    hazard_scheduler #(.LOAD_LAT(3), .CNT_W(32)) u_l3 (
        .clk(clk), .rst(rst), .RS1_D(rs1_d), .RS2_D(rs2_d), .RS1_E(rs1_e), .RS2_E(rs2_e),
        .RD_E(rd_e), .RegWriteE(regwrite_e), .ResultSrcE(resultsrc_e), .PCSrcE(pcsrc_e),
        .RD_M(rd_m), .RegWriteM(regwrite_m), .RD_W(rd_w), .RegWriteW(regwrite_w),
        .cnt_clr(cnt_clr), .StallF(stf[1]), .StallD(std[1]), .FlushD(fd[1]),
        .flushD_load_hazard(fld[1]), .flushD_branch_hazard(flb[1]),
        .ForwardAE(fae[1]), .ForwardBE(fbe[1]),
        .stall_cnt(sc[1]), .flush_cnt(fc[1]), .load_hz_cnt(lc[1]));

    hazard_scheduler #(.LOAD_LAT(4), .CNT_W(4)) u_l4 (
        .clk(clk), .rst(rst), .RS1_D(rs1_d), .RS2_D(rs2_d), .RS1_E(rs1_e), .RS2_E(rs2_e),
        .RD_E(rd_e), .RegWriteE(regwrite_e), .ResultSrcE(resultsrc_e), .PCSrcE(pcsrc_e),
        .RD_M(rd_m), .RegWriteM(regwrite_m), .RD_W(rd_w), .RegWriteW(regwrite_w),
        .cnt_clr(cnt_clr), .StallF(stf[2]), .StallD(std[2]), .FlushD(fd[2]),
        .flushD_load_hazard(fld[2]), .flushD_branch_hazard(flb[2]),
        .ForwardAE(fae[2]), .ForwardBE(fbe[2]),
        .stall_cnt(sc4), .flush_cnt(fc4), .load_hz_cnt(lc4));

    function automatic int lat_of(input int i);
        return (i == 0) ? 1 : ((i == 1) ? 3 : 4);
    endfunction

    function automatic logic [31:0] max_of(input int i);
        return (i == 2) ? 32'd15 : 32'hFFFF_FFFF;
    endfunction

    // Reference bypass rule: newest producer (memory) first, x0 excluded.
    function automatic logic [1:0] ref_fwd(input logic [4:0] rs, input logic [4:0] rdm,
                                           input logic wm, input logic [4:0] rdw,
                                           input logic ww);
        if (wm && rdm != 5'd0 && rdm == rs) return 2'b10;
        if (ww && rdw != 5'd0 && rdw == rs) return 2'b01;
        return 2'b00;
    endfunction

    task automatic clear_inputs();
        rs1_d = 5'd0; rs2_d = 5'd0; rs1_e = 5'd0; rs2_e = 5'd0; rd_e = 5'd0;
        rd_m = 5'd0; rd_w = 5'd0; regwrite_e = 1'b0; regwrite_m = 1'b0;
        regwrite_w = 1'b0; pcsrc_e = 1'b0; cnt_clr = 1'b0; resultsrc_e = 2'b00;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    // lw x5 in execute, add x6,x5,x7 in decode
    task automatic set_load_use();
        regwrite_e = 1'b1; resultsrc_e = 2'b01; rd_e = 5'd5; rs1_d = 5'd5; rs2_d = 5'd7;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b0;
        #2;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({stf[i], std[i], fd[i], fld[i], flb[i], fae[i], fbe[i]} !== 9'd0 ||
                {sc[i], fc[i], lc[i]} !== 96'd0) begin
                failures++;
                $display("FAIL reset_state dut%0d outputs=%b counters=%0d/%0d/%0d required all 0",
                         i, {stf[i], std[i], fd[i], fld[i], flb[i], fae[i], fbe[i]},
                         sc[i], fc[i], lc[i]);
            end
        end
        tick();
        rst = 1'b1;
    endtask

    task automatic test_load_use_lat1();
        do_reset();
        set_load_use();
        @(negedge clk);
        checks++;
        if ({stf[0], std[0], fld[0]} !== 3'b111) begin
            failures++;
            $display("FAIL lat1_stall got=%b required=111", {stf[0], std[0], fld[0]});
        end
        tick();
        regwrite_e = 1'b0; resultsrc_e = 2'b00; rd_e = 5'd0; rd_m = 5'd5; regwrite_m = 1'b1;
        @(negedge clk);
        checks++;
        if ({stf[0], std[0], fld[0]} !== 3'b000) begin
            failures++;
            $display("FAIL lat1_release got=%b required=000", {stf[0], std[0], fld[0]});
        end
        tick();
        rd_m = 5'd0; regwrite_m = 1'b0; rd_w = 5'd5; regwrite_w = 1'b1;
        rs1_e = 5'd5; rs2_e = 5'd7; rs1_d = 5'd0; rs2_d = 5'd0;
        @(negedge clk);
        checks++;
        if (fae[0] !== 2'b01 || fbe[0] !== 2'b00) begin
            failures++;
            $display("FAIL lat1_forward got A=%b B=%b required A=01 B=00", fae[0], fbe[0]);
        end
        checks++;
        if (sc[0] !== 32'd1 || lc[0] !== 32'd1) begin
            failures++;
            $display("FAIL lat1_counters got stall=%0d load=%0d required 1/1", sc[0], lc[0]);
        end
        clear_inputs();
    endtask

    task automatic test_load_use_lat3();
        do_reset();
        set_load_use();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if ({stf[1], std[1], fld[1]} !== 3'b111) begin
                failures++;
                $display("FAIL lat3_stall cycle%0d got=%b required=111", c, {stf[1], std[1], fld[1]});
            end
            tick();
            regwrite_e = 1'b0; resultsrc_e = 2'b00; rd_e = 5'd0;
        end
        @(negedge clk);
        checks++;
        if ({stf[1], std[1], fld[1]} !== 3'b000) begin
            failures++;
            $display("FAIL lat3_release got=%b required=000", {stf[1], std[1], fld[1]});
        end
        checks++;
        if (sc[1] !== 32'd3 || lc[1] !== 32'd1) begin
            failures++;
            $display("FAIL lat3_counters got stall=%0d load=%0d required 3/1", sc[1], lc[1]);
        end
        clear_inputs();
    endtask

    task automatic test_branch_vs_load();
        do_reset();
        set_load_use();
        pcsrc_e = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({fd[i], flb[i], stf[i], std[i], fld[i]} !== 5'b11000) begin
                failures++;
                $display("FAIL branch_wins dut%0d got=%b required=11000",
                         i, {fd[i], flb[i], stf[i], std[i], fld[i]});
            end
        end
        tick();
        clear_inputs();
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (fc[i] !== 32'd1 || lc[i] !== 32'd0 || sc[i] !== 32'd0) begin
                failures++;
                $display("FAIL branch_counters dut%0d got flush=%0d load=%0d stall=%0d required 1/0/0",
                         i, fc[i], lc[i], sc[i]);
            end
        end
        tick();
    endtask

    task automatic test_forward_priority();
        clear_inputs();
        rd_m = 5'd3; rd_w = 5'd3; rs1_e = 5'd3; regwrite_m = 1'b1; regwrite_w = 1'b1;
        @(negedge clk);
        checks++;
        if (fae[0] !== 2'b10) begin
            failures++;
            $display("FAIL fwd_mem_priority got=%b required=10", fae[0]);
        end
        regwrite_m = 1'b0;
        #1;
        checks++;
        if (fae[0] !== 2'b01) begin
            failures++;
            $display("FAIL fwd_wb_only got=%b required=01", fae[0]);
        end
        rs1_e = 5'd0; rd_m = 5'd0; regwrite_m = 1'b1; rs2_e = 5'd3;
        #1;
        checks++;
        if (fae[0] !== 2'b00 || fbe[0] !== 2'b01) begin
            failures++;
            $display("FAIL fwd_x0 got A=%b B=%b required A=00 B=01", fae[0], fbe[0]);
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        set_load_use();
        tick();
        regwrite_e = 1'b0; resultsrc_e = 2'b00; rd_e = 5'd0;
        @(negedge clk);
        checks++;
        if ({stf[2], std[2], fld[2]} !== 3'b111) begin
            failures++;
            $display("FAIL midrst_second_stall got=%b required=111", {stf[2], std[2], fld[2]});
        end
        #1;
        rst = 1'b0;
        #1;
        checks++;
        if ({stf[2], std[2], fld[2], fd[2], flb[2]} !== 5'b00000 || sc[2] !== 32'd0 || lc[2] !== 32'd0) begin
            failures++;
            $display("FAIL midrst_immediate got=%b stall_cnt=%0d load_cnt=%0d required 00000/0/0",
                     {stf[2], std[2], fld[2], fd[2], flb[2]}, sc[2], lc[2]);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({stf[2], std[2], fld[2]} !== 3'b000 || sc[2] !== 32'd0 || lc[2] !== 32'd0) begin
            failures++;
            $display("FAIL midrst_after_release got=%b stall_cnt=%0d load_cnt=%0d required 000/0/0",
                     {stf[2], std[2], fld[2]}, sc[2], lc[2]);
        end
        tick();
    endtask

    task automatic test_saturation();
        do_reset();
        set_load_use();
        repeat (20) tick();
        @(negedge clk);
        checks++;
        if (sc[2] !== 32'd15 || sc[0] !== 32'd20 || sc[1] !== 32'd20) begin
            failures++;
            $display("FAIL sat_stall got l4=%0d l1=%0d l3=%0d required 15/20/20", sc[2], sc[0], sc[1]);
        end
        checks++;
        if (lc[0] !== 32'd20 || lc[1] !== 32'd7 || lc[2] !== 32'd5) begin
            failures++;
            $display("FAIL sat_load_cnt got l1=%0d l3=%0d l4=%0d required 20/7/5", lc[0], lc[1], lc[2]);
        end
        cnt_clr = 1'b1;
        #1;
        checks++;
        if (std[2] !== 1'b1) begin
            failures++;
            $display("FAIL clr_with_stall got StallD=%b required=1", std[2]);
        end
        tick();
        clear_inputs();
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (sc[i] !== 32'd0 || lc[i] !== 32'd0) begin
                failures++;
                $display("FAIL clr_result dut%0d got stall=%0d load=%0d required 0/0", i, sc[i], lc[i]);
            end
        end
        tick();
    endtask

    task automatic test_random(input int n);
        int          busy [3];
        logic [31:0] ms [3];
        logic [31:0] mf [3];
        logic [31:0] ml [3];
        logic        lu, stall, ent;
        logic [1:0]  fa, fb;
        logic [8:0]  exp_o;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            busy[i] = 0; ms[i] = 32'd0; mf[i] = 32'd0; ml[i] = 32'd0;
        end
        for (int c = 0; c < n; c++) begin
            rs1_d = 5'($urandom_range(0, 3)); rs2_d = 5'($urandom_range(0, 3));
            rs1_e = 5'($urandom_range(0, 3)); rs2_e = 5'($urandom_range(0, 3));
            rd_e = 5'($urandom_range(0, 3)); rd_m = 5'($urandom_range(0, 3));
            rd_w = 5'($urandom_range(0, 3));
            regwrite_e = 1'($urandom_range(0, 1)); regwrite_m = 1'($urandom_range(0, 1));
            regwrite_w = 1'($urandom_range(0, 1));
            resultsrc_e = ($urandom_range(0, 1) == 1) ? 2'b01 : 2'($urandom_range(0, 3));
            pcsrc_e = ($urandom_range(0, 7) == 0);
            cnt_clr = ($urandom_range(0, 31) == 0);
            lu = regwrite_e && resultsrc_e == 2'b01 && rd_e != 5'd0 && (rd_e == rs1_d || rd_e == rs2_d);
            fa = ref_fwd(rs1_e, rd_m, regwrite_m, rd_w, regwrite_w);
            fb = ref_fwd(rs2_e, rd_m, regwrite_m, rd_w, regwrite_w);
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                stall = !pcsrc_e && (busy[i] > 0 || lu);
                ent   = !pcsrc_e && busy[i] == 0 && lu;
                exp_o = {stall, stall, pcsrc_e, stall, pcsrc_e, fa, fb};
                checks++;
                if ({stf[i], std[i], fd[i], fld[i], flb[i], fae[i], fbe[i]} !== exp_o) begin
                    failures++;
                    $display("FAIL rand_outputs cyc%0d dut%0d got=%b required=%b", c, i,
                             {stf[i], std[i], fd[i], fld[i], flb[i], fae[i], fbe[i]}, exp_o);
                end
                checks++;
                if (sc[i] !== ms[i] || fc[i] !== mf[i] || lc[i] !== ml[i]) begin
                    failures++;
                    $display("FAIL rand_counters cyc%0d dut%0d got=%0d/%0d/%0d required=%0d/%0d/%0d",
                             c, i, sc[i], fc[i], lc[i], ms[i], mf[i], ml[i]);
                end
                if (cnt_clr) begin
                    ms[i] = 32'd0; mf[i] = 32'd0; ml[i] = 32'd0;
                end else begin
                    if (stall && ms[i] != max_of(i)) ms[i] = ms[i] + 32'd1;
                    if (pcsrc_e && mf[i] != max_of(i)) mf[i] = mf[i] + 32'd1;
                    if (ent && ml[i] != max_of(i)) ml[i] = ml[i] + 32'd1;
                end
                if (pcsrc_e) busy[i] = 0;
                else if (busy[i] > 0) busy[i] = busy[i] - 1;
                else if (lu) busy[i] = lat_of(i) - 1;
            end
            tick();
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        #3;
        test_reset();
        test_load_use_lat1();
        test_load_use_lat3();
        test_branch_vs_load();
        test_forward_priority();
        test_reset_mid_stall();
        test_saturation();
        test_random(600);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_scheduler.md
# hazard_scheduler

Pipeline hazard controller for the five-stage RV32I core. It observes register addresses and control bits from the decode, execute, memory and writeback stages and drives the stall, flush and forwarding controls. These are the IF/ID stall and flush, the ID/EX `flushD_load_hazard` and `flushD_branch_hazard` inputs of the decode stage, and the execute-stage operand bypass selects. A small FSM sequences multi-cycle load-use stalls, and saturating counters expose stall and flush statistics for verification and performance tracking.

## Interface
Parameters:
- `LOAD_LAT`, default 1: bubbles inserted per load-use hazard, range 1–7.
- `CNT_W`, default 32: width of the statistics counters.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `RS1_D`, `RS2_D`  in  5  source registers of the instruction in decode (`InstrD[19:15]`, `InstrD[24:20]`).
- `RS1_E`, `RS2_E`, `RD_E`  in  5  source and destination registers in execute.
- `RegWriteE`  in  1  execute-stage register write enable.
- `ResultSrcE`  in  2  execute-stage result select; `2'b01` marks a load.
- `PCSrcE`  in  1  taken branch or jump resolved in execute.
- `RD_M`, `RegWriteM`  in  5 / 1  memory-stage destination and write enable.
- `RD_W`, `RegWriteW`  in  5 / 1  writeback-stage destination and write enable.
- `cnt_clr`  in  1  synchronous clear of all counters.
- `StallF`  out  1  hold the PC.
- `StallD`  out  1  hold the IF/ID register.
- `FlushD`  out  1  clear IF/ID to a NOP.
- `flushD_load_hazard`  out  1  bubble into ID/EX for a load-use stall.
- `flushD_branch_hazard`  out  1  bubble into ID/EX for a taken branch.
- `ForwardAE`, `ForwardBE`  out  2  operand bypass selects: `00` register file, `10` memory-stage ALU result, `01` `ResultW`.
- `stall_cnt`, `flush_cnt`, `load_hz_cnt`  out  `CNT_W`  statistics counters.

## Operation
- Load-use detect (`lu`): `RegWriteE && ResultSrcE==2'b01 && RD_E!=0 && (RD_E==RS1_D || RD_E==RS2_D)`.
- FSM states:
  - **RUN**
    - `lu && !PCSrcE`: assert `StallF`, `StallD`, `flushD_load_hazard`; load `rem = LOAD_LAT-1`; go to `LD_STALL` if `LOAD_LAT>1`, otherwise stay in `RUN`.
  - **LD_STALL**
    - Assert `StallF`, `StallD`, `flushD_load_hazard` every cycle and decrement `rem`.
    - Return to `RUN` on the cycle `rem==0`; that cycle still stalls.
    - No re-detection happens in this state.
- Branch flush, any state: `PCSrcE` asserts `FlushD` and `flushD_branch_hazard`.
  - It overrides the stalls: `StallF` and `StallD` are 0 that cycle.
  - The FSM returns to `RUN` and `rem` clears.
- Forwarding, evaluated independently for `RS1_E`→`ForwardAE` and `RS2_E`→`ForwardBE`:
  - Select `10` if `RegWriteM && RD_M!=0 && RD_M==RS`.
  - Else select `01` if `RegWriteW && RD_W!=0 && RD_W==RS`.
  - Else select `00`.
  - The memory stage has priority over writeback; `x0` is never forwarded.
- Counters (saturating at all-ones; `cnt_clr` has priority over increment):
  - `stall_cnt` increments on each cycle `StallD` is 1.
  - `flush_cnt` increments on each cycle `flushD_branch_hazard` is 1.
  - `load_hz_cnt` increments once per detected hazard, i.e. on the RUN→stall entry.

## Timing
- Hazard and forwarding outputs are combinational (Mealy) from the inputs and the registered FSM state, valid in the same cycle the condition is present.
- Total stall per load-use hazard is exactly `LOAD_LAT` cycles. The dependent instruction enters execute `LOAD_LAT+1` cycles after detection.
- While `StallD` is held, decode re-reads the register file each cycle, so a load retiring during the stall is captured on release.
- Reset (`rst`=0, asynchronous):
  - The FSM goes to `RUN` with `rem=0`.
  - All counters are 0.
  - With inputs at reset values, all stall, flush and forward outputs are 0/`00`.
- Reset asserted mid-stall aborts the stall immediately; there is no stall on the cycle after release.
- Simultaneous `lu` and `PCSrcE`: the branch flush wins, no stall, and `load_hz_cnt` does not increment.
- `cnt_clr` together with an increment event: the counter becomes 0.

## Test plan
- **Load-use, `LOAD_LAT=1`.** Stimulus: `lw x5` in execute, `add x6,x5,x7` in decode. Required:
  - `StallF`, `StallD`, `flushD_load_hazard` are 1 for exactly one cycle.
  - Next cycle `ForwardAE=01` (x5 in writeback).
  - `stall_cnt=1`, `load_hz_cnt=1`.
- **Load-use, `LOAD_LAT=3`.** Stimulus: same sequence. Required:
  - Stalls for three consecutive cycles, then the FSM is back in `RUN`.
  - `stall_cnt=3`, `load_hz_cnt=1`.
- **Branch versus load-use, same cycle.** Stimulus: `PCSrcE=1` together with `lu`. Required:
  - `FlushD=1`, `flushD_branch_hazard=1`, `StallF=0`, `StallD=0`.
  - `flush_cnt=1`, `load_hz_cnt=0`.
- **Forward priority.** Stimulus: `RD_M=RD_W=RS1_E=3`, both write enables set. Required:
  - `ForwardAE=10`.
  - With `RS1_E=0` and `RD_M=0`, `RegWriteM=1`: `ForwardAE=00`.
- **Reset mid-stall.** Stimulus: `LOAD_LAT=4`, `rst` pulsed low in the second stall cycle. Required:
  - All outputs are 0 immediately.
  - No stall after release; counters read 0.
- **Saturation and clear.** Stimulus: `CNT_W=4`, 20 stall cycles, then `cnt_clr` together with a stall. Required:
  - `stall_cnt` holds at 15.
  - After the clear cycle it reads 0.
